// File: rtl/sdr_qsram_ctrl_pkg.sv
// qsram_pkg: state encoding, default timing values and counter sizing
// helper shared by the SDR QSRAM controller and its refresh timer.
package qsram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      READ_WAIT,
      REFRESH
   } qsram_state_e;

   localparam int DEF_READ_LATENCY     = 2;
   localparam int DEF_REFRESH_INTERVAL = 780;
   localparam int DEF_REFRESH_CYCLES   = 4;

   // Bits needed for a down-counter that holds 0 .. n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdr_qsram_ctrl_if.sv
// sdr_qsram_ctrl_if: host request/response channel plus the device bus,
// with the bidirectional data lines split into out / in / output-enable.
interface sdr_qsram_ctrl_if #(
   parameter int ADDR_WIDTH = 33,
   parameter int DATA_WIDTH = 9
);
   logic                  ReqValid;
   logic                  ReqReady;
   logic                  ReqWrite;
   logic [ADDR_WIDTH-1:0] ReqAddress;
   logic [DATA_WIDTH-1:0] ReqWData;
   logic                  RspValid;
   logic [DATA_WIDTH-1:0] RspData;
   logic                  RspError;
   logic                  RefreshMiss;
   logic [ADDR_WIDTH-1:0] MemAddress;
   logic [DATA_WIDTH-1:0] MemDataOut;
   logic [DATA_WIDTH-1:0] MemDataIn;
   logic                  MemDataOe;
   logic                  MemEnable;
   logic                  MemRead;
   logic                  MemWrite;
   logic                  MemRefresh;

   // Host side (also supplies the device read data in a bench).
   modport master (
      output ReqValid, ReqWrite, ReqAddress, ReqWData, MemDataIn,
      input  ReqReady, RspValid, RspData, RspError, RefreshMiss,
             MemAddress, MemDataOut, MemDataOe, MemEnable, MemRead, MemWrite, MemRefresh
   );

   // Controller side.
   modport slave (
      input  ReqValid, ReqWrite, ReqAddress, ReqWData, MemDataIn,
      output ReqReady, RspValid, RspData, RspError, RefreshMiss,
             MemAddress, MemDataOut, MemDataOe, MemEnable, MemRead, MemWrite, MemRefresh
   );
endinterface

// File: rtl/sdr_qsram_ctrl_refresh_timer.sv
// qsram_refresh_timer: free-running refresh interval counter. Raises a
// pending flag on every expiry, cleared by the controller's ack on entry to
// REFRESH; flags a sticky miss when an expiry finds a refresh still pending.
module qsram_refresh_timer
   import qsram_pkg::*;
#(
   parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
   input  logic Clock,
   input  logic ResetN,
   input  logic ack,
   output logic pending,
   output logic miss
);
   localparam int               CNT_W  = cnt_w(REFRESH_INTERVAL);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

   logic [CNT_W-1:0] cnt;

   // Interval countdown with pending/miss bookkeeping; a new expiry wins over a same-edge ack
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         cnt     <= RELOAD;
         pending <= 1'b0;
         miss    <= 1'b0;
      end else if (cnt == '0) begin
         cnt     <= RELOAD;
         pending <= 1'b1;
         if (pending && !ack) miss <= 1'b1;
      end else begin
         cnt <= cnt - 1'b1;
         if (ack) pending <= 1'b0;
      end
   end

endmodule

// File: rtl/sdr_qsram_ctrl.sv
// sdr_qsram_ctrl: single-port controller for the SDR QSRAM device model.
// Sequences host reads/writes onto the device strobes, returns read data a
// fixed number of cycles after the read strobe and inserts refresh bursts.
// Build option: define QSRAM_PARITY_EN to generate even parity in the top
// data bit on writes and report a parity error on read responses.
module sdr_qsram_ctrl
   import qsram_pkg::*;
#(
   parameter int ADDR_WIDTH       = 33,
   parameter int DATA_WIDTH       = 9,
   parameter int READ_LATENCY     = DEF_READ_LATENCY,
   parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
   parameter int REFRESH_CYCLES   = DEF_REFRESH_CYCLES
) (
   input logic             Clock,
   input logic             ResetN,
   sdr_qsram_ctrl_if.slave bus
);
   localparam int PH_MAX = (READ_LATENCY > REFRESH_CYCLES) ? READ_LATENCY : REFRESH_CYCLES;
   localparam int PH_W   = cnt_w(PH_MAX);

   qsram_state_e          state;
   logic [PH_W-1:0]       phase;
   logic                  refresh_pending;
   logic                  refresh_ack;
   logic                  refresh_miss;
   logic                  xfer;
   logic                  mem_en, mem_rd, mem_wr, mem_rf, mem_oe;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_dout;
   logic                  rsp_vld;
   logic [DATA_WIDTH-1:0] rsp_data;

`ifdef QSRAM_PARITY_EN
   logic rsp_err;

   // Top bit is replaced by even parity over the payload bits.
   function automatic logic [DATA_WIDTH-1:0] wr_word(input logic [DATA_WIDTH-1:0] d);
      return {^d[DATA_WIDTH-2:0], d[DATA_WIDTH-2:0]};
   endfunction

   // Any odd number of ones across the whole stored word is an error.
   function automatic logic rd_err(input logic [DATA_WIDTH-1:0] d);
      return ^d;
   endfunction

   // Parity flag captured alongside the read word
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN)                                    rsp_err <= 1'b0;
      else if (state == READ_WAIT && phase == '0)     rsp_err <= rd_err(bus.MemDataIn);
   end

   assign bus.RspError = rsp_err;
`else
   function automatic logic [DATA_WIDTH-1:0] wr_word(input logic [DATA_WIDTH-1:0] d);
      return d;
   endfunction

   assign bus.RspError = 1'b0;
`endif

   // Ready depends only on registered state, never on ReqValid.
   assign bus.ReqReady = (state == IDLE) && !refresh_pending;
   assign xfer         = bus.ReqValid && bus.ReqReady;
   assign refresh_ack  = (state == IDLE) && refresh_pending;

   qsram_refresh_timer #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL)
   ) u_refresh_timer (
      .Clock   (Clock),
      .ResetN  (ResetN),
      .ack     (refresh_ack),
      .pending (refresh_pending),
      .miss    (refresh_miss)
   );

   // Request/refresh sequencer; strobes are registered for the cycle the state is entered
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state    <= IDLE;
         phase    <= '0;
         mem_en   <= 1'b0;
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         mem_rf   <= 1'b0;
         mem_oe   <= 1'b0;
         mem_addr <= '0;
         mem_dout <= '0;
         rsp_vld  <= 1'b0;
         rsp_data <= '0;
      end else begin
         mem_en  <= 1'b0;
         mem_rd  <= 1'b0;
         mem_wr  <= 1'b0;
         mem_rf  <= 1'b0;
         mem_oe  <= 1'b0;
         rsp_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (refresh_pending) begin
                  state  <= REFRESH;
                  phase  <= PH_W'(REFRESH_CYCLES - 1);
                  mem_en <= 1'b1;
                  mem_rf <= 1'b1;
               end else if (xfer && bus.ReqWrite) begin
                  state    <= WRITE;
                  mem_en   <= 1'b1;
                  mem_wr   <= 1'b1;
                  mem_oe   <= 1'b1;
                  mem_addr <= bus.ReqAddress;
                  mem_dout <= wr_word(bus.ReqWData);
               end else if (xfer) begin
                  state    <= READ;
                  mem_en   <= 1'b1;
                  mem_rd   <= 1'b1;
                  mem_addr <= bus.ReqAddress;
               end
            end
            WRITE: state <= IDLE;
            READ: begin
               state <= READ_WAIT;
               phase <= PH_W'(READ_LATENCY - 1);
            end
            READ_WAIT: begin
               if (phase == '0) begin
                  state    <= IDLE;
                  rsp_vld  <= 1'b1;
                  rsp_data <= bus.MemDataIn;
               end else begin
                  phase <= phase - 1'b1;
               end
            end
            REFRESH: begin
               if (phase == '0) begin
                  state <= IDLE;
               end else begin
                  phase  <= phase - 1'b1;
                  mem_en <= 1'b1;
                  mem_rf <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.MemEnable   = mem_en;
   assign bus.MemRead     = mem_rd;
   assign bus.MemWrite    = mem_wr;
   assign bus.MemRefresh  = mem_rf;
   assign bus.MemDataOe   = mem_oe;
   assign bus.MemAddress  = mem_addr;
   assign bus.MemDataOut  = mem_dout;
   assign bus.RspValid    = rsp_vld;
   assign bus.RspData     = rsp_data;
   assign bus.RefreshMiss = refresh_miss;

endmodule

// File: tb/tb_sdr_qsram_ctrl.sv
// tb_sdr_qsram_ctrl: directed bench for sdr_qsram_ctrl. Main instance uses a
// 16-cycle refresh interval; a second instance with a 4-cycle interval is
// driven with a continuous read stream to provoke RefreshMiss.
`timescale 1ns/1ps
module tb_sdr_qsram_ctrl;
   localparam int AW = 33;
   localparam int DW = 9;
   localparam int RL = 2;
   localparam int RI = 16;
   localparam int RC = 4;

`ifdef QSRAM_PARITY_EN
   localparam logic          EXP_ERR_103 = 1'b1;
   localparam logic [DW-1:0] EXP_WR_1FF  = 9'h0FF;
`else
   localparam logic          EXP_ERR_103 = 1'b0;
   localparam logic [DW-1:0] EXP_WR_1FF  = 9'h1FF;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic rst2_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   sdr_qsram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
   sdr_qsram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

   sdr_qsram_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
      .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
   ) dut (.Clock(clk), .ResetN(rst_n), .bus(bus));

   sdr_qsram_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL),
      .REFRESH_INTERVAL(4), .REFRESH_CYCLES(RC)
   ) dut2 (.Clock(clk), .ResetN(rst2_n), .bus(bus2));

   // Device model: small direct-mapped store, read data valid RL cycles after the strobe cycle
   logic [DW-1:0] mem [16];
   logic [1:0]    vpipe = '0;
   logic [DW-1:0] dpipe0 = '0;
   logic [DW-1:0] dpipe1 = '0;
   logic          ovr_en;
   logic [DW-1:0] ovr_val;

   always @(posedge clk) begin
      if (bus.MemWrite) mem[bus.MemAddress[3:0]] <= bus.MemDataOut;
      vpipe  <= {vpipe[0], bus.MemRead};
      dpipe0 <= ovr_en ? ovr_val : mem[bus.MemAddress[3:0]];
      dpipe1 <= dpipe0;
   end

   assign bus.MemDataIn  = vpipe[1] ? dpipe1 : 9'h1EE;
   assign bus2.MemDataIn = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.ReqValid   = 1'b1;
      bus.ReqWrite   = wr;
      bus.ReqAddress = addr;
      bus.ReqWData   = data;
   endtask

   // Refresh strobe expected in cycles 17..20, 33..36, ...; ready low from the expiry cycle.
   function automatic logic exp_rf(input int n);
      return (n >= 17) && (((n - 1) % 16) < 4);
   endfunction

   function automatic logic exp_busy(input int n);
      return (n >= 16) && ((n % 16) <= 4);
   endfunction

   initial begin
      rst_n = 1'b0;
      rst2_n = 1'b0;
      ovr_en = 1'b0;
      ovr_val = '0;
      bus.ReqValid = 1'b0;
      bus.ReqWrite = 1'b0;
      bus.ReqAddress = '0;
      bus.ReqWData = '0;
      bus2.ReqValid = 1'b1;
      bus2.ReqWrite = 1'b0;
      bus2.ReqAddress = '0;
      bus2.ReqWData = '0;

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_flags", {bus.MemEnable, bus.MemRead, bus.MemWrite, bus.MemRefresh,
                              bus.MemDataOe, bus.RspValid, bus.RspError, bus.RefreshMiss}, 8'h00);
      check_val("rst_addr", bus.MemAddress, 0);
      check_val("rst_dout", bus.MemDataOut, 0);

      rst_n = 1'b1;
      cyc = 0;
      while (cyc < 5) tick();
      check_val("idle_ready", bus.ReqReady, 1);
      check_val("idle_flags", {bus.MemEnable, bus.MemRead, bus.MemWrite, bus.MemRefresh,
                               bus.MemDataOe, bus.RspValid}, 6'h00);

      // write then read back the same address
      drive_req(1'b1, 33'h1_0000_0005, 9'h0A5);
      tick(); // 6
      check_val("wr_strobes", {bus.MemEnable, bus.MemWrite, bus.MemDataOe, bus.MemRead, bus.MemRefresh}, 5'b11100);
      check_val("wr_addr", bus.MemAddress, 33'h1_0000_0005);
      check_val("wr_data", bus.MemDataOut, 9'h0A5);
      check_val("wr_busy", bus.ReqReady, 0);
      bus.ReqValid = 1'b0;
      tick(); // 7
      check_val("wr_done", {bus.MemEnable, bus.MemWrite, bus.MemDataOe}, 3'b000);
      check_val("wr_ready", bus.ReqReady, 1);
      check_val("wr_addr_hold", bus.MemAddress, 33'h1_0000_0005);
      check_val("wr_no_rsp", bus.RspValid, 0);
      drive_req(1'b0, 33'h1_0000_0005, 9'h000);
      tick(); // 8
      check_val("rd_strobes", {bus.MemEnable, bus.MemWrite, bus.MemDataOe, bus.MemRead, bus.MemRefresh}, 5'b10010);
      bus.ReqValid = 1'b0;
      tick(); // 9
      check_val("rd_wait1", {bus.MemEnable, bus.MemRead, bus.RspValid, bus.ReqReady}, 4'b0000);
      tick(); // 10
      check_val("rd_wait2", {bus.RspValid, bus.ReqReady}, 2'b00);
      tick(); // 11
      check_val("rd_rsp_vld", bus.RspValid, 1);
      check_val("rd_rsp_data", bus.RspData, 9'h0A5);
      check_val("rd_rsp_err", bus.RspError, 0);
      check_val("rd_ready", bus.ReqReady, 1);
      tick(); // 12
      check_val("rd_rsp_pulse", bus.RspValid, 0);

      // idle refresh schedule
      while (cyc < 46) begin
         tick();
         check_val($sformatf("ref_rf@%0d", cyc), bus.MemRefresh, exp_rf(cyc));
         check_val($sformatf("ref_en@%0d", cyc), bus.MemEnable, exp_rf(cyc));
         check_val($sformatf("ref_rdy@%0d", cyc), bus.ReqReady, !exp_busy(cyc));
      end

      // read accepted on the expiry edge completes before the refresh
      tick(); // 47
      drive_req(1'b0, 33'h1_0000_0005, 9'h000);
      tick(); // 48
      check_val("exp_rd_strobe", {bus.MemRead, bus.MemRefresh}, 2'b10);
      bus.ReqValid = 1'b0;
      tick(); tick(); tick(); // 51
      check_val("exp_rsp_vld", bus.RspValid, 1);
      check_val("exp_rsp_data", bus.RspData, 9'h0A5);
      check_val("exp_rsp_norf", bus.MemRefresh, 0);
      check_val("exp_rsp_rdy", bus.ReqReady, 0);
      tick(); // 52
      check_val("exp_rf_start", bus.MemRefresh, 1);
      tick(); tick(); tick(); // 55
      check_val("exp_rf_last", bus.MemRefresh, 1);
      tick(); // 56
      check_val("exp_rf_end", {bus.MemRefresh, bus.ReqReady}, 2'b01);

      // data path / parity handling
      drive_req(1'b1, 33'h0_0000_0002, 9'h003);
      tick(); // 57
      check_val("par_wr_003", bus.MemDataOut, 9'h003);
      bus.ReqValid = 1'b0;
      tick(); // 58
      ovr_en = 1'b1;
      ovr_val = 9'h103;
      drive_req(1'b0, 33'h0_0000_0002, 9'h000);
      tick(); // 59
      bus.ReqValid = 1'b0;
      tick(); tick(); tick(); // 62
      ovr_en = 1'b0;
      check_val("par_rsp_vld", bus.RspValid, 1);
      check_val("par_rsp_data", bus.RspData, 9'h103);
      check_val("par_rsp_err", bus.RspError, EXP_ERR_103);
      drive_req(1'b1, 33'h0_0000_0003, 9'h1FF);
      tick(); // 63
      check_val("par_wr_1ff", bus.MemDataOut, EXP_WR_1FF);
      bus.ReqValid = 1'b0;
      tick(); // 64
      check_val("no_miss", bus.RefreshMiss, 0);

      // asynchronous reset in the middle of a read
      while (cyc < 70) tick();
      drive_req(1'b0, 33'h1_0000_0005, 9'h000);
      tick(); // 71
      check_val("rr_read", bus.MemRead, 1);
      bus.ReqValid = 1'b0;
      tick(); tick(); // 73, last READ_WAIT cycle
      rst_n = 1'b0;
      #1;
      check_val("rr_async_flags", {bus.MemRead, bus.RspValid, bus.MemEnable}, 3'b000);
      check_val("rr_async_addr", bus.MemAddress, 0);
      check_val("rr_async_data", bus.RspData, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      check_val("rr_ready", bus.ReqReady, 1);
      repeat (4) begin
         check_val("rr_no_rsp", bus.RspValid, 0);
         tick();
      end

      // back-to-back reads with a 4-cycle refresh interval
      rst2_n = 1'b1;
      cyc = 0;
      tick(); // 1
      check_val("miss_init", bus2.RefreshMiss, 0);
      while (cyc < 4) tick();
      check_val("miss_rd_rsp", bus2.RspValid, 1);
      while (cyc < 10) tick();
      check_val("miss_early", bus2.RefreshMiss, 0);
      while (cyc < 40) tick();
      check_val("miss_set", bus2.RefreshMiss, 1);
      while (cyc < 60) tick();
      check_val("miss_sticky", bus2.RefreshMiss, 1);
      check_val("miss_excl", {bus2.MemRead, bus2.MemWrite, bus2.MemRefresh} inside {3'b000, 3'b100, 3'b010, 3'b001}, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
